// File: rtl/sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver
//
// Time-multiplexed scan driver for an 8-digit, common-anode 7-segment display.
// Each digit owns one slot of SLOT clock cycles. The first BLANK_CYCLES cycles
// of every slot keep all anodes off so the previous digit's cathode pattern
// does not ghost onto the next digit. The digit enables, codes, character-mode
// bits and decimal points are captured into shadow registers once per frame,
// so a register write can never tear a frame.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous, active-high reset
//   i_enables     per-digit enable, bit n = digit n (digit 0 is rightmost)
//   i_digits      per-digit code, byte n = digit n
//   i_char_en     1: byte n is ASCII, 0: low nibble of byte n is hex
//   i_dp          per-digit decimal point request, active-high
//   o_an          anode selects, active-low, at most one low at a time
//   o_seg         cathodes {g,f,e,d,c,b,a}, active-low
//   o_dp          decimal-point cathode, active-low
//   o_frame_tick  one-cycle pulse following the frame snapshot
// ---------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_enables,
    input  logic [63:0] i_digits,
    input  logic [7:0]  i_char_en,
    input  logic [7:0]  i_dp,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic        o_frame_tick
);

    localparam int SLOT  = CLK_FREQ_HZ / (REFRESH_HZ * 8);
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);

    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // A slot must leave at least one lit cycle after the blanking gap.
    if (SLOT <= BLANK_CYCLES) begin : g_bad_slot
        $error("sevseg_scan_driver: SLOT must exceed BLANK_CYCLES");
    end

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Glyph tables (active-low, bit order {g,f,e,d,c,b,a})
    // -----------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // pos is the alphabet position 1..26, shared by upper and lower case.
    // Letters that cannot be drawn recognisably (K, M, V, W, X) stay blank.
    function automatic logic [6:0] letter_glyph(input logic [4:0] pos);
        logic [6:0] g;
        case (pos)
            5'd1:  g = 7'h08;  // A
            5'd2:  g = 7'h03;  // b
            5'd3:  g = 7'h46;  // C
            5'd4:  g = 7'h21;  // d
            5'd5:  g = 7'h06;  // E
            5'd6:  g = 7'h0E;  // F
            5'd7:  g = 7'h42;  // G
            5'd8:  g = 7'h09;  // H
            5'd9:  g = 7'h4F;  // I
            5'd10: g = 7'h61;  // J
            5'd12: g = 7'h47;  // L
            5'd14: g = 7'h2B;  // n
            5'd15: g = 7'h40;  // O
            5'd16: g = 7'h0C;  // P
            5'd17: g = 7'h18;  // q
            5'd18: g = 7'h2F;  // r
            5'd19: g = 7'h12;  // S
            5'd20: g = 7'h07;  // t
            5'd21: g = 7'h41;  // U
            5'd25: g = 7'h11;  // y
            5'd26: g = 7'h24;  // Z
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] decode_glyph(input logic [7:0] code,
                                                input logic       is_char);
        logic [6:0] g;
        if (!is_char) begin
            g = hex_glyph(code[3:0]);
        end else if (code >= 8'h30 && code <= 8'h39) begin
            g = hex_glyph(code[3:0]);
        end else if ((code[7:5] == 3'b010 || code[7:5] == 3'b011) &&
                     code[4:0] != 5'd0 && code[4:0] <= 5'd26) begin
            // 'A'..'Z' = 0x41..0x5A and 'a'..'z' = 0x61..0x7A share low 5 bits.
            g = letter_glyph(code[4:0]);
        end else if (code == 8'h2D) begin
            g = SEG_DASH;
        end else begin
            g = SEG_OFF;
        end
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_p0;
    logic [2:0]       idx_p0;
    state_t           state_p0;

    logic [7:0]       en_sh;
    logic [63:0]      dig_sh;
    logic [7:0]       chr_sh;
    logic [7:0]       dp_sh;

    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx_nxt;
    logic             snap;
    logic [7:0]       cur_code;
    logic [6:0]       cur_glyph;
    logic [7:0]       cur_an;

    always_comb begin
        cnt_nxt   = (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + 1'b1;
        idx_nxt   = (cnt_p0 == CNT_LAST) ? idx_p0 + 3'd1 : idx_p0;
        snap      = (cnt_p0 == '0) && (idx_p0 == 3'd0);
        cur_code  = dig_sh[{idx_p0, 3'b000} +: 8];
        cur_glyph = decode_glyph(cur_code, chr_sh[idx_p0]);
        // A disabled digit still consumes its slot, just with the anode off.
        cur_an    = en_sh[idx_p0] ? ~(8'b1 << idx_p0) : AN_OFF;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_p0       <= '0;
            idx_p0       <= 3'd0;
            state_p0     <= BLANK;
            en_sh        <= 8'h00;
            dig_sh       <= 64'h0;
            chr_sh       <= 8'h00;
            dp_sh        <= 8'h00;
            o_an         <= AN_OFF;
            o_seg        <= SEG_OFF;
            o_dp         <= 1'b1;
            o_frame_tick <= 1'b0;
        end else begin
            // ---- stage p0: slot counter, digit index, blank/on state ----
            cnt_p0 <= cnt_nxt;
            idx_p0 <= idx_nxt;
            if (cnt_nxt == CNT_ON) begin
                state_p0 <= ON;
            end else if (cnt_nxt == '0) begin
                state_p0 <= BLANK;
            end

            // Frame snapshot: taken while the outputs are blanked, so the
            // new codes first reach the pins in slot 0 of this frame.
            if (snap) begin
                en_sh  <= i_enables;
                dig_sh <= i_digits;
                chr_sh <= i_char_en;
                dp_sh  <= i_dp;
            end
            o_frame_tick <= snap;

            // ---- stage p1: registered pin drive from the p0 state ----
            if (state_p0 == ON) begin
                o_an  <= cur_an;
                o_seg <= cur_glyph;
                o_dp  <= ~dp_sh[idx_p0];
            end else begin
                o_an  <= AN_OFF;
                o_seg <= SEG_OFF;
                o_dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevseg_scan_driver
//
// Stimulus process loads one directed frame at a time and pushes the
// hand-computed per-digit expectation into a queue. The monitor pops one
// entry per o_frame_tick and checks every cycle of that frame: phase 0 is
// the tick cycle, phases 10d and 10d+1 are blank, phases 10d+2..10d+9 show
// digit d.
// ---------------------------------------------------------------------------
module tb_sevseg_scan_driver;

    typedef struct packed {
        logic [7:0]      en;
        logic [7:0]      dp;
        logic [7:0][6:0] seg;   // seg[d] = expected glyph for digit d
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  enables;
    logic [63:0] digits;
    logic [7:0]  char_en;
    logic [7:0]  dp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_tick;

    int     n_vec = 0;
    int     n_bad = 0;
    bit     chk_en = 1'b0;
    frame_t sb[$];

    sevseg_scan_driver #(
        .CLK_FREQ_HZ (800),
        .REFRESH_HZ  (10),
        .BLANK_CYCLES(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enables   (enables),
        .i_digits    (digits),
        .i_char_en   (char_en),
        .i_dp        (dp),
        .o_an        (an),
        .o_seg       (seg),
        .o_dp        (dp_n),
        .o_frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] e, input logic [7:0] c,
                        input logic [63:0] d, input logic [7:0] p,
                        input logic [7:0][6:0] g);
        frame_t f;
        enables = e;
        char_en = c;
        digits  = d;
        dp      = p;
        f.en    = e;
        f.dp    = p;
        f.seg   = g;
        sb.push_back(f);
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_tick && cyc < 200);
        if (!frame_tick) begin
            n_vec++;
            n_bad++;
            $display("FAIL tick_timeout: no o_frame_tick within %0d cycles", cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    frame_t cur;
    bit     active = 1'b0;
    int     ph = 0;

    always @(negedge clk) begin
        n_vec++;
        if (!$onehot0(~an)) begin
            n_bad++;
            $display("FAIL onehot_an: o_an=%0h", an);
        end
        if (!chk_en) begin
            active = 1'b0;
        end else begin
            if (frame_tick) begin
                if (active) begin
                    n_vec++;
                    if (ph + 1 != 80) begin
                        n_bad++;
                        $display("FAIL tick_period: got %0d expected 80", ph + 1);
                    end
                end
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL frame_queue: tick with no expected frame");
                    active = 1'b0;
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    ph     = 0;
                end
            end else if (active) begin
                ph++;
                if (ph >= 80) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL tick_missing: no tick at phase %0d", ph);
                    active = 1'b0;
                end
            end
            if (active) begin
                logic [7:0] e_an;
                logic [6:0] e_seg;
                logic       e_dp;
                int         d;
                d = ph / 10;
                if (ph % 10 < 2) begin
                    e_an  = 8'hFF;
                    e_seg = 7'h7F;
                    e_dp  = 1'b1;
                end else begin
                    e_an  = cur.en[d] ? ~(8'b1 << d) : 8'hFF;
                    e_seg = cur.seg[d];
                    e_dp  = ~cur.dp[d];
                end
                n_vec++;
                if (an !== e_an || seg !== e_seg || dp_n !== e_dp) begin
                    n_bad++;
                    $display("FAIL pins ph=%0d: got an=%0h seg=%0h dp=%0b expected an=%0h seg=%0h dp=%0b",
                             ph, an, seg, dp_n, e_an, e_seg, e_dp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst     = 1'b1;
        enables = 8'h00;
        digits  = 64'h0;
        char_en = 8'h00;
        dp      = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_an",   an,         8'hFF);
        check("rst_seg",  seg,        7'h7F);
        check("rst_dp",   dp_n,       1'b1);
        check("rst_tick", frame_tick, 1'b0);

        // Hex digits 0..7 on all positions.
        load(8'hFF, 8'h00, 64'h0706050403020100, 8'h00,
             {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
        chk_en = 1'b1;
        rst    = 1'b0;
        wait_tick(cyc);
        check("first_tick_latency", cyc, 1);

        for (int v = 2; v <= 5; v++) begin
            // Inputs change 20 cycles into the frame; the current frame
            // must keep showing the previous snapshot.
            repeat (20) @(negedge clk);
            case (v)
                2: load(8'h05, 8'h00, 64'h0706050403020100, 8'h00,
                        {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});
                3: load(8'hFF, 8'hFF, {"HELLO-", 8'h7E, " "}, 8'h00,
                        {7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h3F, 7'h7F, 7'h7F});
                4: load(8'hFF, 8'h00, 64'h1A2B3C4D5E6F780F, 8'h80,
                        {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h00, 7'h0E});
                default: load(8'hA5, 8'hFF, "Pq0Zt9aK", 8'h3C,
                        {7'h0C, 7'h18, 7'h40, 7'h24, 7'h07, 7'h10, 7'h08, 7'h7F});
            endcase
            wait_tick(cyc);
            check("tick_after_write", cyc, 60);
        end

        // Reset pulse while digit 5 is lit.
        repeat (55) @(negedge clk);
        chk_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("midrst_an",   an,         8'hFF);
        check("midrst_seg",  seg,        7'h7F);
        check("midrst_dp",   dp_n,       1'b1);
        check("midrst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        load(8'hFF, 8'h00, 64'h08090A0B0C0D0E0F, 8'h01,
             {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
        chk_en = 1'b1;
        wait_tick(cyc);
        check("post_reset_tick_latency", cyc, 1);

        repeat (79) @(negedge clk);
        chk_en = 1'b0;
        check("queue_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
